dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 107 ++++++++++
 tb/tb_dmem_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a fixed-latency data memory; done pulses LAT+1 cycles after the grant.
// Backpressure: a port holds req until its done pulse, and the CPU is stalled until then.
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LAT    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic              cpu_done,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_done,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;
    localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

    logic [0:0]        state;
    logic [3:0]        cnt;
    logic              owner;
    logic              last_owner;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;

    logic cpu_eff;
    logic ext_eff;
    logic grant_sel;

    // A port is masked in its own done cycle so the finished request is not re-granted.
    always_comb begin
        cpu_eff   = cpu_req & ~cpu_done;
        ext_eff   = ext_req & ~ext_done;
        grant_sel = (cpu_eff & ext_eff) ? ~last_owner : ext_eff;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            cpu_done   <= 1'b0;
            ext_done   <= 1'b0;
            cpu_rdata  <= '0;
            ext_rdata  <= '0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
        end else begin
            cpu_done <= 1'b0;
            ext_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_eff | ext_eff) begin
                        owner     <= grant_sel;
                        lat_we    <= grant_sel ? ext_we    : cpu_we;
                        lat_addr  <= grant_sel ? ext_addr  : cpu_addr;
                        lat_wdata <= grant_sel ? ext_wdata : cpu_wdata;
                        cnt       <= CNT_INIT;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == 4'd0) begin
                        if (!lat_we) begin
                            if (owner) ext_rdata <= mem_rdata;
                            else       cpu_rdata <= mem_rdata;
                        end
                        if (owner) ext_done <= 1'b1;
                        else       cpu_done <= 1'b1;
                        last_owner <= owner;
                        state      <= IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        mem_re    = (state == BUSY) & ~lat_we;
        mem_we    = (state == BUSY) & lat_we;
        mem_addr  = lat_addr;
        mem_wdata = lat_wdata;
        cpu_stall = cpu_req & ~cpu_done;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: stimulus queues expected completions, a monitor checks every done pulse.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, cpu_stall, cpu_done;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        ext_req, ext_we, ext_done;
    logic [31:0] ext_addr, ext_wdata, ext_rdata;
    logic        mem_re, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(2)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_done(ext_done), .ext_rdata(ext_rdata),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Small data memory: combinational read, write on the rising edge.
    logic [31:0] mem [256];
    assign mem_rdata = mem[mem_addr[7:0]];
    always @(posedge clk) if (mem_we) mem[mem_addr[7:0]] = mem_wdata;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          port;
        logic [31:0] rdata;
        int          at;
    } exp_t;
    exp_t sbq[$];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push(input bit port, input logic [31:0] rd, input int at);
        exp_t e;
        e.port  = port;
        e.rdata = rd;
        e.at    = at;
        sbq.push_back(e);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic bus(input string nm, input logic re, input logic we, input logic [31:0] addr);
        chk({nm, "_re"}, 32'(mem_re), 32'(re));
        chk({nm, "_we"}, 32'(mem_we), 32'(we));
        chk({nm, "_addr"}, mem_addr, addr);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (cpu_done === 1'b1 || ext_done === 1'b1) begin
                chk("done_exclusive", 32'(cpu_done & ext_done), 32'd0);
                if (sbq.size() == 0) begin
                    chk("unexpected_done", 32'(sbq.size()), 32'd1);
                end else begin
                    e = sbq.pop_front();
                    chk("done_port", 32'(ext_done), 32'(e.port));
                    chk("done_cycle", 32'(cyc), 32'(e.at));
                    chk("done_rdata", e.port ? ext_rdata : cpu_rdata, e.rdata);
                end
            end
        end
    end

    initial begin
        int t;
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        mem[8'h10] = 32'hDEADBEEF;
        reset = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h0; ext_wdata = 32'h0;

        // Reset with both requests high, then look at the first post-reset cycle.
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        bus("rst", 1'b0, 1'b0, 32'h0);
        chk("rst_cpu_done", 32'(cpu_done), 32'd0);
        chk("rst_ext_done", 32'(ext_done), 32'd0);
        chk("rst_cpu_rdata", cpu_rdata, 32'h0);
        chk("rst_ext_rdata", ext_rdata, 32'h0);
        chk("rst_cpu_stall", 32'(cpu_stall), 32'd1);
        cpu_req = 1'b0; ext_req = 1'b0;

        // Tie after reset: CPU read first, then ext write.
        @(posedge clk); #1; t = cyc;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h20; ext_wdata = 32'h12345678;
        push(1'b0, 32'hDEADBEEF, t + 3);
        push(1'b1, 32'h0, t + 6);
        wait_cyc(t + 1); bus("tie_c1", 1'b1, 1'b0, 32'h10);
        chk("tie_stall1", 32'(cpu_stall), 32'd1);
        wait_cyc(t + 2); bus("tie_c2", 1'b1, 1'b0, 32'h10);
        chk("tie_stall2", 32'(cpu_stall), 32'd1);
        wait_cyc(t + 3); bus("tie_c3", 1'b0, 1'b0, 32'h10);
        chk("tie_stall3", 32'(cpu_stall), 32'd0);
        cpu_req = 1'b0;
        wait_cyc(t + 4); bus("tie_c4", 1'b0, 1'b1, 32'h20);
        chk("tie_wdata4", mem_wdata, 32'h12345678);
        wait_cyc(t + 5); bus("tie_c5", 1'b0, 1'b1, 32'h20);
        wait_cyc(t + 6); ext_req = 1'b0;

        // Single CPU read of the freshly written word; inputs change mid-flight.
        @(posedge clk); #1; t = cyc;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h20;
        push(1'b0, 32'h12345678, t + 3);
        wait_cyc(t + 1); bus("rd_c1", 1'b1, 1'b0, 32'h20);
        cpu_addr = 32'h99; cpu_we = 1'b1;
        wait_cyc(t + 2); bus("rd_c2", 1'b1, 1'b0, 32'h20);
        wait_cyc(t + 3); cpu_req = 1'b0;

        // Tie after a CPU completion: ext wins, CPU write leaves cpu_rdata intact.
        @(posedge clk); #1; t = cyc;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h30; cpu_wdata = 32'hA5A50001;
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h10;
        push(1'b1, 32'hDEADBEEF, t + 3);
        push(1'b0, 32'h12345678, t + 6);
        wait_cyc(t + 1); bus("rr_c1", 1'b1, 1'b0, 32'h10);
        wait_cyc(t + 3); ext_req = 1'b0;
        wait_cyc(t + 4); bus("rr_c4", 1'b0, 1'b1, 32'h30);
        chk("rr_wdata4", mem_wdata, 32'hA5A50001);
        wait_cyc(t + 6); cpu_req = 1'b0;

        // Continuous requests from both ports: grants alternate ext, CPU, ext, CPU.
        @(posedge clk); #1; t = cyc;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h30;
        push(1'b1, 32'hA5A50001, t + 3);
        push(1'b0, 32'hDEADBEEF, t + 6);
        push(1'b1, 32'hA5A50001, t + 9);
        push(1'b0, 32'hDEADBEEF, t + 12);
        wait_cyc(t + 9); ext_req = 1'b0;
        wait_cyc(t + 12); cpu_req = 1'b0;

        // Reset pulse in the first BUSY cycle aborts the read; held request is regranted.
        @(posedge clk); #1; t = cyc;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        push(1'b0, 32'hDEADBEEF, t + 5);
        wait_cyc(t + 1); bus("abort_c1", 1'b1, 1'b0, 32'h10);
        reset = 1'b1;
        wait_cyc(t + 2); bus("abort_c2", 1'b0, 1'b0, 32'h0);
        chk("abort_cpu_rdata", cpu_rdata, 32'h0);
        chk("abort_stall", 32'(cpu_stall), 32'd1);
        reset = 1'b0;
        wait_cyc(t + 3); bus("abort_c3", 1'b1, 1'b0, 32'h10);
        wait_cyc(t + 5); cpu_req = 1'b0;

        // Ext request dropped after the grant still completes.
        @(posedge clk); #1; t = cyc;
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h30;
        push(1'b1, 32'hA5A50001, t + 3);
        wait_cyc(t + 1); bus("drop_c1", 1'b1, 1'b0, 32'h30);
        ext_req = 1'b0; ext_addr = 32'h55;
        wait_cyc(t + 2); bus("drop_c2", 1'b1, 1'b0, 32'h30);
        wait_cyc(t + 4); bus("drop_c4", 1'b0, 1'b0, 32'h30);

        wait_cyc(t + 10);
        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
